// File: rtl/call_stack.sv
// Hardware subroutine stack: saves {return PC, flags} on a call and presents the
// top entry combinationally so a return restores both in the cycle of the pop.
module call_stack #(
    parameter int DEPTH      = 8,
    parameter int PC_WIDTH   = 8,
    parameter int FLAG_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_push_en,
    input  logic                        in_pop_en,
    input  logic [PC_WIDTH-1:0]         in_pc,
    input  logic [FLAG_WIDTH-1:0]       in_flags,
    output logic [PC_WIDTH-1:0]         out_ret_pc,
    output logic [FLAG_WIDTH-1:0]       out_stack_flags,
    output logic                        out_empty,
    output logic                        out_full,
    output logic [$clog2(DEPTH):0]      out_depth,
    output logic                        out_overflow,
    output logic                        out_underflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
    localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [AW-1:0]  IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [FLAG_WIDTH-1:0] flags;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [SPW-1:0]  sp_q;
    logic [SPW-1:0]  sp_d;
    logic            overflow_q;
    logic            overflow_d;
    logic            underflow_q;
    logic            underflow_d;

    logic            empty_s;
    logic            full_s;
    logic [AW-1:0]   top_idx_s;
    entry_t          top_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_idx_s;
    entry_t          wr_data_s;

    // Occupancy decode and top-of-stack selection.
    always_comb begin
        empty_s   = (sp_q == SP_ZERO);
        full_s    = (sp_q == SP_FULL);
        // When sp == DEPTH the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
        top_idx_s = sp_q[AW-1:0] - IDX_ONE;
        if (empty_s) begin
            top_s = '0;
        end else begin
            top_s = mem_q[top_idx_s];
        end
    end

    // Next-state computation for the pointer, sticky errors and the entry write.
    always_comb begin
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en_s     = 1'b0;
        wr_idx_s    = sp_q[AW-1:0];
        wr_data_s   = '{pc: in_pc, flags: in_flags};

        case ({in_push_en, in_pop_en})
            2'b10: begin
                if (full_s) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                    sp_d    = sp_q + SP_ONE;
                end
            end
            2'b01: begin
                if (empty_s) begin
                    underflow_d = 1'b1;
                end else begin
                    sp_d = sp_q - SP_ONE;
                end
            end
            2'b11: begin
                // A tail return-then-call replaces the top in place; on an empty
                // stack the pop has nothing to consume, so only the push lands.
                if (empty_s) begin
                    wr_en_s     = 1'b1;
                    sp_d        = sp_q + SP_ONE;
                    underflow_d = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end
            end
            default: begin
                sp_d = sp_q;
            end
        endcase
    end

    // Pointer and sticky error registers; reset overrides any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= SP_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents are never cleared, only hidden while empty.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign out_ret_pc      = top_s.pc;
    assign out_stack_flags = top_s.flags;
    assign out_empty       = empty_s;
    assign out_full        = full_s;
    assign out_depth       = sp_q;
    assign out_overflow    = overflow_q;
    assign out_underflow   = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: a vector table for the basic call/return flows
// plus hand-written sequences for fill/overflow, reset-during-push and call/return.
module tb_call_stack;

    logic        clk;
    logic        reset;
    logic        in_push_en;
    logic        in_pop_en;
    logic [7:0]  in_pc;
    logic [3:0]  in_flags;
    logic [7:0]  out_ret_pc;
    logic [3:0]  out_stack_flags;
    logic        out_empty;
    logic        out_full;
    logic [3:0]  out_depth;
    logic        out_overflow;
    logic        out_underflow;

    int tests_run;
    int tests_failed;

    logic [7:0] cu_pc;
    logic [3:0] cu_flags;

    call_stack #(.DEPTH(8), .PC_WIDTH(8), .FLAG_WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_push_en      (in_push_en),
        .in_pop_en       (in_pop_en),
        .in_pc           (in_pc),
        .in_flags        (in_flags),
        .out_ret_pc      (out_ret_pc),
        .out_stack_flags (out_stack_flags),
        .out_empty       (out_empty),
        .out_full        (out_full),
        .out_depth       (out_depth),
        .out_overflow    (out_overflow),
        .out_underflow   (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the control unit: latches the restored PC/flags on a return edge.
    always @(posedge clk) begin
        if (in_pop_en) begin
            cu_pc    <= out_ret_pc;
            cu_flags <= out_stack_flags;
        end
    end

    typedef struct {
        logic       rst;
        logic       push;
        logic       pop;
        logic [7:0] pc;
        logic [3:0] fl;
        logic [7:0] e_pc;
        logic [3:0] e_fl;
        logic [3:0] e_d;
        logic       e_ov;
        logic       e_un;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_pc, input logic [3:0] e_fl,
                               input logic [3:0] e_d, input logic e_ov, input logic e_un);
        check({tag, ".pc"},    32'(out_ret_pc),      32'(e_pc));
        check({tag, ".flags"}, 32'(out_stack_flags), 32'(e_fl));
        check({tag, ".depth"}, 32'(out_depth),       32'(e_d));
        check({tag, ".empty"}, 32'(out_empty),       32'(e_d == 4'd0));
        check({tag, ".full"},  32'(out_full),        32'(e_d == 4'd8));
        check({tag, ".ovf"},   32'(out_overflow),    32'(e_ov));
        check({tag, ".unf"},   32'(out_underflow),   32'(e_un));
    endtask

    // Drive one cycle's inputs just after the falling edge and let them settle.
    task automatic apply(input logic rst, input logic push, input logic pop,
                         input logic [7:0] pc, input logic [3:0] fl);
        @(negedge clk);
        reset      = rst;
        in_push_en = push;
        in_pop_en  = pop;
        in_pc      = pc;
        in_flags   = fl;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        in_push_en   = 1'b0;
        in_pop_en    = 1'b0;
        in_pc        = 8'h00;
        in_flags     = 4'h0;

        // Each row: inputs for one cycle, and outputs expected while those inputs are held.
        //            rst   push  pop   pc     fl     e_pc   e_fl  e_d   ov    un
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h10, 4'h1, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h20, 4'h2, 8'h10, 4'h1, 4'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h30, 4'h4, 8'h20, 4'h2, 4'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 8'h30, 4'h4, 4'd3, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 8'h20, 4'h2, 4'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 8'h10, 4'h1, 4'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 4'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h42, 4'h3, 8'h00, 4'h0, 4'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h42, 4'h3, 4'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h99, 4'h9, 8'h42, 4'h3, 4'd1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h77, 4'h5, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h20, 4'h2, 8'h77, 4'h5, 4'd1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h55, 4'h8, 8'h20, 4'h2, 4'd2, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 4'h0, 8'h55, 4'h8, 4'd2, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h77, 4'h5, 4'd1, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h77, 4'h5, 4'd1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 4'h0, 4'd0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].pc, tbl[i].fl);
            check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fl, tbl[i].e_d,
                        tbl[i].e_ov, tbl[i].e_un);
        end

        // Fill to DEPTH, replace the top while full, then overflow.
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'(i), 4'(i));
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_state("full", 8'h08, 4'h8, 4'd8, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 8'hAA, 4'hA);
        check_state("full_pp_during", 8'h08, 4'h8, 4'd8, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_state("full_pp_after", 8'hAA, 4'hA, 4'd8, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'hFF, 4'hF);
        check_state("ovf_during", 8'hAA, 4'hA, 4'd8, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_state("ovf_after", 8'hAA, 4'hA, 4'd8, 1'b1, 1'b0);

        // Drain in LIFO order; entries below the replaced top must be intact.
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
            if (k == 0) begin
                check_state("drain0", 8'hAA, 4'hA, 4'd8, 1'b1, 1'b0);
            end else begin
                check_state($sformatf("drain%0d", k), 8'(8 - k), 4'(8 - k), 4'(8 - k), 1'b1, 1'b0);
            end
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_state("drained", 8'h00, 4'h0, 4'd0, 1'b1, 1'b0);

        // Reset coinciding with a push at depth 5 discards everything.
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 4'(i));
        end
        apply(1'b1, 1'b1, 1'b0, 8'h66, 4'h6);
        check_state("rst_push_during", 8'h64, 4'h4, 4'd5, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check_state("rst_push_after", 8'h00, 4'h0, 4'd0, 1'b0, 1'b0);

        // Call from address 0x33 with flags 0x1, flags change, then return.
        apply(1'b0, 1'b1, 1'b0, 8'h34, 4'h1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        apply(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        check_state("ret_during", 8'h34, 4'h1, 4'd1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        check("ret_cu_pc",    32'(cu_pc),    32'h34);
        check("ret_cu_flags", 32'(cu_flags), 32'h1);
        check_state("ret_after", 8'h00, 4'h0, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/call_stack.md
# call_stack

Hardware subroutine stack directly downstream of the micro-sequenced control unit. On a call it captures the return PC together with the current 4-bit flags. On a return it presents the saved PC and flags so the control unit and PC can restore them in the same cycle. The block is driven by the control unit's `out_stack_push_en` / `out_stack_pop_en` strobes, and its flag output feeds the control unit's `in_stack_flags`.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of two, ≥ 2.
- `PC_WIDTH`, 8: width of the saved return address.
- `FLAG_WIDTH`, 4: width of the saved flags.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `in_push_en` input 1: push request; connects to control-unit `out_stack_push_en`.
- `in_pop_en` input 1: pop request; connects to control-unit `out_stack_pop_en`.
- `in_pc` input PC_WIDTH: return address to save (PC already incremented past the call).
- `in_flags` input FLAG_WIDTH: flags to save; connects to control-unit `out_flags`.
- `out_ret_pc` output PC_WIDTH: return address held in the top entry.
- `out_stack_flags` output FLAG_WIDTH: flags held in the top entry; connects to control-unit `in_stack_flags`.
- `out_empty` output 1: stack holds 0 entries.
- `out_full` output 1: stack holds DEPTH entries.
- `out_depth` output clog2(DEPTH)+1: current number of entries.
- `out_overflow` output 1: sticky; set by a push while full.
- `out_underflow` output 1: sticky; set by a pop while empty.

## Operation
- Storage: DEPTH entries of `{pc, flags}`, plus a count register `sp` in the range 0..DEPTH. The top entry is `mem[sp-1]`.
- Top-of-stack outputs are combinational from `sp` and `mem`:
  - `out_ret_pc = mem[sp-1].pc` and `out_stack_flags = mem[sp-1].flags` when `sp > 0`.
  - Both are all-zero when `sp == 0`.
- Push only, not full: write `{in_pc, in_flags}` to `mem[sp]`; `sp <= sp+1`.
- Push only, full: no write; `sp` unchanged; `out_overflow <= 1`.
- Pop only, not empty: `sp <= sp-1`. The entry popped is the one visible on the outputs during the pop cycle.
- Pop only, empty: `sp` unchanged; `out_underflow <= 1`.
- Push and pop in the same cycle:
  - Not empty: the outputs show the old top during the cycle; at the edge the top entry `mem[sp-1]` is overwritten with `{in_pc, in_flags}`; `sp` unchanged; no error.
  - Empty: behaves as push only, and `out_underflow <= 1`.
- Neither request: hold all state.
- The sticky error flags are cleared only by `reset`.
- `out_empty = (sp == 0)`, `out_full = (sp == DEPTH)`, `out_depth = sp`; all decoded combinationally from `sp`.

## Timing
- Reset values, effective from the first edge with `reset = 1`:
  - `sp = 0`, `out_overflow = 0`, `out_underflow = 0`.
  - Therefore `out_empty = 1`, `out_full = 0`, `out_depth = 0`, `out_ret_pc = 0`, `out_stack_flags = 0`.
  - `mem` contents are not cleared; they are unobservable while empty.
- `reset` has priority over push and pop in the same cycle. A reset in the middle of a call/return sequence discards all entries.
- Push latency: the pushed entry appears on the outputs in the cycle after the push edge; `out_depth` updates at the same edge.
- Pop latency: zero.
  - The popped data is valid combinationally throughout the cycle in which `in_pop_en` is high, so the control unit latches it on that same edge.
  - After the edge, the outputs show the next-lower entry, or zero if the stack is now empty.
- No handshake or backpressure: requests are single-cycle strobes, and every strobe is consumed in the cycle it is asserted.
- Error flags rise on the edge following the offending request and are then visible.

## Test plan
- Reset, then 3 pushes of (pc, flags) = (0x10, 0x1), (0x20, 0x2), (0x30, 0x4) → `out_depth = 3`; top shows 0x30 / 0x4. Then 3 pops: during each pop cycle the outputs show 0x30/0x4, then 0x20/0x2, then 0x10/0x1; after the last pop `out_empty = 1` and the outputs are 0.
- Push DEPTH=8 entries (pc = 0x01..0x08) → `out_full = 1`. A 9th push (0xFF) → `out_overflow = 1`, top still 0x08, depth 8.
- Pop while empty after reset → `out_underflow = 1`, depth stays 0, outputs 0. A subsequent push of (0x42, 0x3) works normally.
- Simultaneous push and pop with depth 2, top = (0x20, 0x2), new = (0x55, 0x8) → during the cycle the outputs show 0x20/0x2; after the edge they show 0x55/0x8 and depth stays 2.
- Assert `reset` in the same cycle as a push with depth 5 → next cycle depth 0, empty, both error flags 0.
- Integrate with the control unit: execute a call (opcode 10100) then a return (10101) while the flags are 0x1, changing the flags to 0x0 between them → after the return the control-unit flags read 0x1 and the PC equals the call address + 1.
